// File: rtl/stream_pkg.sv
// stream_pkg: shared types and width helpers for the stream FIFO family.
//   state_t      - occupancy state of the FIFO (EMPTY / ACTIVE / FULL)
//   ptr_width()  - index width of the (DEPTH-1)-entry circular buffer
//   count_width()- width of an occupancy counter that can hold DEPTH
package stream_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_t;

  // A one-entry buffer (DEPTH=2) still needs a 1-bit index to stay legal.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 2) ? $clog2(depth - 1) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// stream_fifo_mem: (DEPTH-1) x WIDTH register file backing the FIFO body.
// One synchronous write port, one combinational read port, no reset.
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write index (0 .. DEPTH-2)
//   wr_data  - write word
//   rd_addr  - read index (0 .. DEPTH-2)
//   rd_data  - word at rd_addr, combinational
module stream_fifo_mem
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: DEPTH-entry valid/ready FIFO with registered handshake outputs.
// The head word lives in its own register (`out`) that drives output_data;
// the remaining DEPTH-1 words live in a circular buffer (stream_fifo_mem).
// input_ready, output_valid, count and almost_full are all registered from the
// next-state count, so there is no combinational path from output_ready to
// input_ready, nor from input_data to output_data.
//
// Ports:
//   clk, reset    - single clock, synchronous active-high reset
//   flush         - discard all contents (only with STREAM_FIFO_FLUSH_EN)
//   input_valid   - upstream word present
//   input_ready   - FIFO can accept a word (registered)
//   input_data    - upstream word
//   output_valid  - head word present (registered)
//   output_ready  - downstream accepts the head word
//   output_data   - head word (from register)
//   count         - words held, including the head (registered)
//   almost_full   - count >= AFULL (registered)
//
// Build options:
//   STREAM_FIFO_FLUSH_EN - adds the flush input
//   FORMAL               - enables embedded properties
module stream_fifo
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AFULL = DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef STREAM_FIFO_FLUSH_EN
  input  logic                          flush,
`endif
  input  logic                          input_valid,
  output logic                          input_ready,
  input  logic [WIDTH-1:0]              input_data,
  output logic                          output_valid,
  input  logic                          output_ready,
  output logic [WIDTH-1:0]              output_data,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          almost_full
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 2);

  state_t           state, state_n;
  logic [CW-1:0]    count_n;

  // Pointers are {wrap, index}; equal pointers mean an empty buffer, equal
  // indices with differing wrap bits mean a full one.
  logic [PW:0]      rptr, wptr;
  logic             buf_empty;

  logic             clear;
  logic             insert, remove;
  logic             load_out, out_from_buf, wr_en, rd_adv;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] out;

`ifdef STREAM_FIFO_FLUSH_EN
  assign clear = reset | flush;
`else
  assign clear = reset;
`endif

  assign insert      = input_valid & input_ready;
  assign remove      = output_valid & output_ready;
  assign buf_empty   = (rptr == wptr);
  assign output_data = out;

  // Index runs 0 .. DEPTH-2, so wrap is modulo DEPTH-1 rather than a power of two.
  function automatic logic [PW:0] bump(input logic [PW:0] p);
    if (p[PW-1:0] == LAST_IDX) begin
      return {~p[PW], {PW{1'b0}}};
    end
    return p + 1'b1;
  endfunction

  always_comb begin
    state_n      = state;
    count_n      = count;
    load_out     = 1'b0;
    out_from_buf = 1'b0;
    wr_en        = 1'b0;
    rd_adv       = 1'b0;
    unique case (state)
      EMPTY: begin
        if (insert) begin
          load_out = 1'b1;
          count_n  = CW'(1);
          state_n  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (insert && !remove) begin
          wr_en   = 1'b1;
          count_n = count + 1'b1;
          if (count_n == DEPTH_C) begin
            state_n = FULL;
          end
        end else if (!insert && remove) begin
          count_n = count - 1'b1;
          if (buf_empty) begin
            state_n = EMPTY;
          end else begin
            load_out     = 1'b1;
            out_from_buf = 1'b1;
            rd_adv       = 1'b1;
          end
        end else if (insert && remove) begin
          // Empty buffer: the new word goes straight to the head register.
          load_out = 1'b1;
          if (!buf_empty) begin
            out_from_buf = 1'b1;
            rd_adv       = 1'b1;
            wr_en        = 1'b1;
          end
        end
      end
      FULL: begin
        if (remove) begin
          load_out     = 1'b1;
          out_from_buf = 1'b1;
          rd_adv       = 1'b1;
          count_n      = count - 1'b1;
          state_n      = ACTIVE;
        end
      end
      default: begin
        state_n = EMPTY;
        count_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state        <= EMPTY;
      count        <= '0;
      output_valid <= 1'b0;
      input_ready  <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      output_valid <= (count_n != '0);
      input_ready  <= (count_n != DEPTH_C);
      almost_full  <= (count_n >= AFULL_C);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (rd_adv) begin
        rptr <= bump(rptr);
      end
      if (wr_en) begin
        wptr <= bump(wptr);
      end
    end
  end

  // Head data register is deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_out) begin
      out <= out_from_buf ? rd_data : input_data;
    end
  end

  stream_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wptr[PW-1:0]),
    .wr_data(input_data),
    .rd_addr(rptr[PW-1:0]),
    .rd_data(rd_data)
  );

`ifdef FORMAL
  a_hold_stable: assert property (@(posedge clk) disable iff (clear)
    output_valid && !output_ready |=> output_valid && $stable(output_data));

  a_count_track: assert property (@(posedge clk) disable iff (clear)
    1'b1 |=> count == $past(count) + CW'($past(insert)) - CW'($past(remove)));

  a_order_empty: assert property (@(posedge clk) disable iff (clear)
    insert && state == EMPTY |=> output_data == $past(input_data));

  a_order_buf: assert property (@(posedge clk) disable iff (clear)
    remove && !buf_empty |=> output_data == $past(rd_data));

  a_empty_novalid: assert property (@(posedge clk)
    state == EMPTY |-> !output_valid);
`endif

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             input_valid = 1'b0;
  logic             output_ready = 1'b0;
  logic [WIDTH-1:0] input_data = '0;
  logic             input_ready;
  logic             output_valid;
  logic             almost_full;
  logic [WIDTH-1:0] output_data;
  logic [CW-1:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the words the FIFO should hold, oldest first.
  logic [WIDTH-1:0] ref_q[$];

  always #5 clk = ~clk;

  stream_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AFULL(AFULL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef STREAM_FIFO_FLUSH_EN
    .flush       (flush),
`endif
    .input_valid (input_valid),
    .input_ready (input_ready),
    .input_data  (input_data),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .output_data (output_data),
    .count       (count),
    .almost_full (almost_full)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus side: every accepted word becomes an expected output.
  always @(negedge clk) begin
    if (reset || flush) begin
      ref_q.delete();
    end else if (input_valid && input_ready) begin
      ref_q.push_back(input_data);
    end
  end

  // Output monitor: pops and compares each word the DUT hands downstream,
  // and checks the head holds steady under backpressure.
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] hold_data = '0;
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_w;
    if (hold_prev) begin
      chk("hold_valid", 64'(output_valid), 64'(1));
      chk("hold_data", 64'(output_data), 64'(hold_data));
    end
    if (!reset && !flush && output_valid && output_ready) begin
      if (ref_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h expected none at %0t", output_data, $time);
      end else begin
        exp_w = ref_q.pop_front();
        chk("out_order", 64'(output_data), 64'(exp_w));
      end
    end
    hold_prev = output_valid && !output_ready && !reset && !flush;
    hold_data = output_data;
  end

  // Status check after every edge, derived from model occupancy.
  always @(posedge clk) begin
    #2;
    chk("count", 64'(count), 64'(ref_q.size()));
    chk("output_valid", 64'(output_valid), 64'(ref_q.size() != 0));
    chk("input_ready", 64'(input_ready), 64'(ref_q.size() != DEPTH));
    chk("almost_full", 64'(almost_full), 64'(ref_q.size() >= AFULL));
    if (ref_q.size() != 0) begin
      chk("head", 64'(output_data), 64'(ref_q[0]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit stalled;
    stalled = 1'b0;

    // Reset values
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_ready", 64'(input_ready), 64'(1));
    chk("rst_valid", 64'(output_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_afull", 64'(almost_full), 64'(0));

    // Fill A0..A3 with downstream stalled
    for (int k = 0; k < 4; k++) begin
      input_valid = 1'b1;
      input_data  = 32'hA0 + 32'(k);
      chk("fill_ready", 64'(input_ready), 64'(1));
      chk("fill_afull", 64'(almost_full), 64'(k >= AFULL));
      step();
    end
    input_valid = 1'b0;
    chk("full_ready", 64'(input_ready), 64'(0));
    chk("full_count", 64'(count), 64'(4));
    chk("full_afull", 64'(almost_full), 64'(1));
    chk("full_head", 64'(output_data), 64'(32'hA0));

    // Drain in order
    output_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 64'(output_valid), 64'(1));
      chk("drain_data", 64'(output_data), 64'(32'hA0 + 32'(k)));
      step();
    end
    chk("drained_valid", 64'(output_valid), 64'(0));
    chk("drained_count", 64'(count), 64'(0));
    output_ready = 1'b0;

    // Streaming: one word per cycle, one cycle of latency
    output_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      input_valid = 1'b1;
      input_data  = 32'(i);
      if (i > 0) begin
        chk("stream_data", 64'(output_data), 64'(i - 1));
        chk("stream_count", 64'(count), 64'(1));
      end
      step();
    end
    input_valid = 1'b0;
    chk("stream_last", 64'(output_data), 64'(15));
    step();
    output_ready = 1'b0;
    chk("stream_empty", 64'(output_valid), 64'(0));

    // Random valid/ready, upstream holds its offer while stalled
    for (int c = 0; c < 1000; c++) begin
      if (!stalled) begin
        input_valid = 1'($urandom_range(0, 1));
        input_data  = $urandom;
      end
      output_ready = 1'($urandom_range(0, 1));
      stalled = input_valid && !input_ready;
      step();
    end
    output_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (!stalled) input_valid = 1'b0;
      stalled = input_valid && !input_ready;
      step();
    end
    chk("rand_drained", 64'(count), 64'(0));
    output_ready = 1'b0;

    // Reset mid-stream with three words held
    for (int k = 0; k < 3; k++) begin
      input_valid = 1'b1;
      input_data  = 32'hB0 + 32'(k);
      step();
    end
    input_valid = 1'b0;
    chk("pre_rst_count", 64'(count), 64'(3));
    reset       = 1'b1;
    input_valid = 1'b1;
    input_data  = 32'hEE;
    step();
    reset       = 1'b0;
    input_valid = 1'b0;
    chk("mid_rst_valid", 64'(output_valid), 64'(0));
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_ready", 64'(input_ready), 64'(1));
    output_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no_stale", 64'(output_valid), 64'(0));
    end
    output_ready = 1'b0;

`ifdef STREAM_FIFO_FLUSH_EN
    // Flush with two held words while 0x55 is offered
    for (int k = 0; k < 2; k++) begin
      input_valid = 1'b1;
      input_data  = 32'hC0 + 32'(k);
      step();
    end
    chk("pre_flush_count", 64'(count), 64'(2));
    flush       = 1'b1;
    input_valid = 1'b1;
    input_data  = 32'h55;
    step();
    flush       = 1'b0;
    input_valid = 1'b0;
    chk("flush_valid", 64'(output_valid), 64'(0));
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_ready", 64'(input_ready), 64'(1));
    input_valid = 1'b1;
    input_data  = 32'h77;
    step();
    input_valid = 1'b0;
    chk("post_flush_valid", 64'(output_valid), 64'(1));
    chk("post_flush_data", 64'(output_data), 64'(32'h77));
    output_ready = 1'b1;
    step();
    chk("post_flush_empty", 64'(output_valid), 64'(0));
    output_ready = 1'b0;
`endif

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
